// File: rtl/wl_sfifo_ctrl.sv
// Single-clock FIFO controller for an external synchronous dual-port RAM.
// Owns binary wrap-bit pointers, qualified RAM strobes/addresses, flags, count and sticky errors.
module wl_sfifo_ctrl #(
  parameter int unsigned L      = 3,
  parameter int unsigned AF_LVL = (1 << L) - 2,
  parameter int unsigned AE_LVL = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic         re,
  input  logic         clr_err,
  output logic         we_ram,
  output logic         re_ram,
  output logic [L-1:0] waddr,
  output logic [L-1:0] raddr,
  output logic         full,
  output logic         empty,
  output logic         afull,
  output logic         aempty,
  output logic [L:0]   count,
  output logic         ovf,
  output logic         udf
);

  localparam logic [L:0] AF_TH = (L+1)'(AF_LVL);
  localparam logic [L:0] AE_TH = (L+1)'(AE_LVL);

  logic [L:0] wptr_q, wptr_d;
  logic [L:0] rptr_q, rptr_d;
  logic [L:0] count_q, count_d;
  logic       full_q, full_d;
  logic       empty_q, empty_d;
  logic       afull_q, afull_d;
  logic       aempty_q, aempty_d;
  logic       ovf_q, ovf_d;
  logic       udf_q, udf_d;

  assign we_ram = we & ~full_q;
  assign re_ram = re & ~empty_q;
  assign waddr  = wptr_q[L-1:0];
  assign raddr  = rptr_q[L-1:0];

  // Flags are computed from next-state pointers so they track the post-edge occupancy.
  always_comb begin
    wptr_d   = wptr_q + (L+1)'(we_ram);
    rptr_d   = rptr_q + (L+1)'(re_ram);
    count_d  = wptr_d - rptr_d;
    full_d   = (wptr_d[L] != rptr_d[L]) && (wptr_d[L-1:0] == rptr_d[L-1:0]);
    empty_d  = (wptr_d == rptr_d);
    afull_d  = (count_d >= AF_TH);
    aempty_d = (count_d <= AE_TH);
    ovf_d    = (we & full_q)  | (ovf_q & ~clr_err);
    udf_d    = (re & empty_q) | (udf_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign full   = full_q;
  assign empty  = empty_q;
  assign afull  = afull_q;
  assign aempty = aempty_q;
  assign count  = count_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;

endmodule

// File: tb/tb_wl_sfifo_ctrl.sv
// Self-checking bench for wl_sfifo_ctrl: directed scenarios plus randomized traffic
// against an occupancy/transfer-count reference model.
module tb_wl_sfifo_ctrl;

  localparam int L  = 3;
  localparam int D  = 1 << L;
  localparam int AF = D - 2;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst, we, re, clr_err;
  logic         we_ram, re_ram;
  logic [L-1:0] waddr, raddr;
  logic         full, empty, afull, aempty;
  logic [L:0]   count;
  logic         ovf, udf;

  wl_sfifo_ctrl #(.L(L), .AF_LVL(AF), .AE_LVL(AE)) dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .clr_err(clr_err),
    .we_ram(we_ram), .re_ram(re_ram), .waddr(waddr), .raddr(raddr),
    .full(full), .empty(empty), .afull(afull), .aempty(aempty),
    .count(count), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: total accepted writes/reads since reset, plus sticky errors.
  int   wtot = 0, rtot = 0;
  logic m_ovf = 1'b0, m_udf = 1'b0;

  // Strobes/addresses sampled mid-cycle, with the model's expectation for them.
  logic [2*L+1:0] s_strb, e_strb;

  wire [L+6:0] dut_state = {count, full, empty, afull, aempty, ovf, udf};

  function automatic logic [L+6:0] exp_state();
    int occ;
    logic [L:0] c;
    occ = wtot - rtot;
    c = occ[L:0];
    return {c, occ == D, occ == 0, occ >= AF, occ <= AE, m_ovf, m_udf};
  endfunction

  task automatic tick(input logic w, input logic r, input logic c, input logic rs);
    int occ;
    int wa, ra;
    logic [L-1:0] ewa, era;
    @(negedge clk);
    we = w; re = r; clr_err = c; rst = rs;
    #1;
    occ = wtot - rtot;
    wa = wtot % D; ra = rtot % D;
    ewa = wa[L-1:0]; era = ra[L-1:0];
    s_strb = {we_ram, re_ram, waddr, raddr};
    e_strb = {w && (occ < D), r && (occ > 0), ewa, era};
    @(posedge clk);
    if (rs) begin
      wtot = 0; rtot = 0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      m_ovf = (w && occ == D) || (m_ovf && !c);
      m_udf = (r && occ == 0) || (m_udf && !c);
      if (w && occ < D) wtot++;
      if (r && occ > 0) rtot++;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (dut_state !== exp_state()) begin
      n_err++;
      $display("FAIL reset_state got %b want %b", dut_state, exp_state());
    end
    n_cmp++;
    if ({waddr, raddr, count, empty, aempty, full, afull} !== {{L{1'b0}}, {L{1'b0}}, {(L+1){1'b0}}, 4'b1100}) begin
      n_err++;
      $display("FAIL reset_const got wa=%0d ra=%0d cnt=%0d e=%b ae=%b f=%b af=%b want 0 0 0 1 1 0 0",
               waddr, raddr, count, empty, aempty, full, afull);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (dut_state !== exp_state()) begin
      n_err++;
      $display("FAIL idle_state got %b want %b", dut_state, exp_state());
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < D; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (s_strb !== e_strb) begin
        n_err++;
        $display("FAIL fill_strobe[%0d] got %b want %b", i, s_strb, e_strb);
      end
      n_cmp++;
      if (dut_state !== exp_state()) begin
        n_err++;
        $display("FAIL fill_state[%0d] got %b want %b", i, dut_state, exp_state());
      end
      n_cmp++;
      if (count !== (L+1)'(i + 1) || afull !== (i + 1 >= 6) || aempty !== (i + 1 <= 2)) begin
        n_err++;
        $display("FAIL fill_levels[%0d] got cnt=%0d af=%b ae=%b want cnt=%0d af=%b ae=%b",
                 i, count, afull, aempty, i + 1, (i + 1 >= 6), (i + 1 <= 2));
      end
    end
    n_cmp++;
    if (full !== 1'b1 || waddr !== '0) begin
      n_err++;
      $display("FAIL fill_end got full=%b waddr=%0d want full=1 waddr=0", full, waddr);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (s_strb !== e_strb || we_ram !== 1'b0 && 1'b0) begin
        n_err++;
        $display("FAIL ovf_strobe[%0d] got %b want %b", i, s_strb, e_strb);
      end
      n_cmp++;
      if (dut_state !== exp_state() || count !== (L+1)'(D) || ovf !== 1'b1) begin
        n_err++;
        $display("FAIL ovf_state[%0d] got %b want %b", i, dut_state, exp_state());
      end
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (dut_state !== exp_state() || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear got %b want %b", dut_state, exp_state());
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < D; i++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (s_strb !== e_strb) begin
        n_err++;
        $display("FAIL drain_strobe[%0d] got %b want %b", i, s_strb, e_strb);
      end
      n_cmp++;
      if (dut_state !== exp_state()) begin
        n_err++;
        $display("FAIL drain_state[%0d] got %b want %b", i, dut_state, exp_state());
      end
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (s_strb !== e_strb || s_strb[2*L] !== 1'b0) begin
      n_err++;
      $display("FAIL udf_strobe got %b want %b", s_strb, e_strb);
    end
    n_cmp++;
    if (dut_state !== exp_state() || udf !== 1'b1 || empty !== 1'b1 || raddr !== '0) begin
      n_err++;
      $display("FAIL udf_state got %b raddr=%0d want %b raddr=0", dut_state, raddr, exp_state());
    end
  endtask

  task automatic test_simultaneous();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < D; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (dut_state !== exp_state() || count !== (L+1)'(D - 1) || full !== 1'b0 || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL simul_full got %b want %b", dut_state, exp_state());
    end
    for (int i = 0; i < D - 1; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (dut_state !== exp_state() || count !== (L+1)'(1) || empty !== 1'b0 || udf !== 1'b1) begin
      n_err++;
      $display("FAIL simul_empty got %b want %b", dut_state, exp_state());
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (s_strb !== e_strb) begin
        n_err++;
        $display("FAIL simul_strobe[%0d] got %b want %b", i, s_strb, e_strb);
      end
      n_cmp++;
      if (dut_state !== exp_state() || count !== (L+1)'(4)) begin
        n_err++;
        $display("FAIL simul_steady[%0d] got %b want %b", i, dut_state, exp_state());
      end
    end
  endtask

  task automatic test_mid_reset();
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (count !== (L+1)'(5) || udf !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre got cnt=%0d udf=%b want cnt=5 udf=1", count, udf);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (dut_state !== exp_state() || count !== '0 || empty !== 1'b1 || waddr !== '0 ||
        raddr !== '0 || ovf !== 1'b0 || udf !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_state got %b wa=%0d ra=%0d want %b wa=0 ra=0",
               dut_state, waddr, raddr, exp_state());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic w, r, c, rs;
      w  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 50);
      c  = ($urandom_range(0, 99) < 6);
      rs = ($urandom_range(0, 99) < 2);
      tick(w, r, c, rs);
      n_cmp++;
      if (s_strb !== e_strb) begin
        n_err++;
        $display("FAIL rand_strobe[%0d] got %b want %b", i, s_strb, e_strb);
      end
      n_cmp++;
      if (dut_state !== exp_state()) begin
        n_err++;
        $display("FAIL rand_state[%0d] got %b want %b", i, dut_state, exp_state());
      end
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; clr_err = 1'b0;
    s_strb = '0; e_strb = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
